// File: rtl/cdc_handshake_tx.sv
// Source-side 4-phase request/acknowledge launcher. It holds one word stable on
// TX_DATA while TX_REQ is high and can optionally abort a transfer when ACK never arrives.
module cdc_handshake_tx #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_REQ,
  input  logic              ACK_SYNC,
  output logic              XFER_DONE,
  output logic              TIMEOUT_ERR,
  input  logic              TIMEOUT_CLR,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_req_q, tx_req_d;
  logic                xfer_done_q, xfer_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q, busy_d;
  logic                aborted_q, aborted_d;
  logic                err_set;
  logic                accept;

  // A stale ACK from the previous handshake must be gone before a new request.
  assign DIN_READY = (state_q == IDLE) && !ACK_SYNC && !RESET;
  assign accept    = DIN_VALID && DIN_READY;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_req_d    = tx_req_q;
    xfer_done_d = 1'b0;
    aborted_d   = aborted_q;
    err_set     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d = DIN;
          tx_req_d  = 1'b1;
          cnt_d     = 16'd0;
          aborted_d = 1'b0;
          state_d   = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ACK_SYNC) begin
          tx_req_d  = 1'b0;
          aborted_d = 1'b0;
          state_d   = WAIT_ACK_LO;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Abort still waits for ACK low so the far side sees a clean 4-phase return.
          tx_req_d  = 1'b0;
          aborted_d = 1'b1;
          err_set   = 1'b1;
          state_d   = WAIT_ACK_LO;
        end else if (TO_EN && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_ACK_LO: begin
        if (!ACK_SYNC) begin
          xfer_done_d = !aborted_q;
          state_d     = IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (err_set) begin
      timeout_err_d = 1'b1;
    end else if (TIMEOUT_CLR) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      tx_data_q     <= '0;
      tx_req_q      <= 1'b0;
      xfer_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_req_q      <= tx_req_d;
      xfer_done_q   <= xfer_done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      aborted_q     <= aborted_d;
    end
  end

  assign TX_DATA     = tx_data_q;
  assign TX_REQ      = tx_req_q;
  assign XFER_DONE   = xfer_done_q;
  assign TIMEOUT_ERR = timeout_err_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed scenarios for cdc_handshake_tx (TIMEOUT_CYC = 8), one task per scenario,
// outputs sampled 1 time unit after each rising edge.
module tb_cdc_handshake_tx;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] tx_data;
  logic        tx_req;
  logic        ack_sync;
  logic        xfer_done;
  logic        timeout_err;
  logic        timeout_clr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cdc_handshake_tx #(.DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .DIN         (din),
    .DIN_VALID   (din_valid),
    .DIN_READY   (din_ready),
    .TX_DATA     (tx_data),
    .TX_REQ      (tx_req),
    .ACK_SYNC    (ack_sync),
    .XFER_DONE   (xfer_done),
    .TIMEOUT_ERR (timeout_err),
    .TIMEOUT_CLR (timeout_clr),
    .BUSY        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 32'hDEAD_BEEF; din_valid = 1'b1; ack_sync = 1'b0; timeout_clr = 1'b0;
    step(); step();
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", tx_req); end
    total++; if (tx_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", tx_data); end
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", xfer_done); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", din_ready); end
    $display("reset: outputs checked after two reset edges");
  endtask

  task automatic test_basic();
    reset = 1'b0;
    din   = 32'hA5A5_0001;
    for (int k = 1; k <= 8; k++) begin
      din_valid = (k == 1);
      ack_sync  = (k >= 4 && k <= 6);
      step();
      total++; if (tx_req !== (k <= 3)) begin bad++; $display("FAIL basic_req edge=%0d got=%b exp=%b", k, tx_req, (k <= 3)); end
      total++; if (xfer_done !== (k == 7)) begin bad++; $display("FAIL basic_done edge=%0d got=%b exp=%b", k, xfer_done, (k == 7)); end
      total++; if (busy !== (k <= 6)) begin bad++; $display("FAIL basic_busy edge=%0d got=%b exp=%b", k, busy, (k <= 6)); end
      total++; if (din_ready !== (k >= 7)) begin bad++; $display("FAIL basic_ready edge=%0d got=%b exp=%b", k, din_ready, (k >= 7)); end
      total++; if (tx_data !== 32'hA5A5_0001) begin bad++; $display("FAIL basic_data edge=%0d got=%h exp=a5a50001", k, tx_data); end
    end
    $display("basic: single transfer of a5a50001 completed");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [31:0] exp_data;
    logic        prev_req;
    int          accepts;
    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
    prev_req = tx_req;
    accepts  = 0;
    for (int k = 1; k <= 13; k++) begin
      din       = (k <= 1) ? w[0] : ((k <= 5) ? w[1] : w[2]);
      din_valid = (k <= 9);
      ack_sync  = (k == 3 || k == 7 || k == 11);
      step();
      exp_data = (k <= 4) ? w[0] : ((k <= 8) ? w[1] : w[2]);
      if (tx_req && !prev_req) begin
        accepts++;
        total++; if (k != 1 + 4 * (accepts - 1)) begin bad++; $display("FAIL b2b_spacing accept=%0d got_edge=%0d exp_edge=%0d", accepts, k, 1 + 4 * (accepts - 1)); end
      end
      prev_req = tx_req;
      total++; if (tx_req !== ((k % 4 == 1 || k % 4 == 2) && k <= 10)) begin bad++; $display("FAIL b2b_req edge=%0d got=%b", k, tx_req); end
      total++; if (xfer_done !== ((k % 4 == 0) && k <= 12)) begin bad++; $display("FAIL b2b_done edge=%0d got=%b", k, xfer_done); end
      total++; if (tx_data !== exp_data) begin bad++; $display("FAIL b2b_data edge=%0d got=%h exp=%h", k, tx_data, exp_data); end
    end
    total++; if (accepts != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", accepts); end
    $display("back_to_back: %0d accepts observed", accepts);
  endtask

  task automatic test_timeout();
    din = 32'h7777_0008;
    ack_sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      din_valid = (k == 1);
      step();
      total++; if (tx_req !== (k <= 8)) begin bad++; $display("FAIL to_req edge=%0d got=%b exp=%b", k, tx_req, (k <= 8)); end
      total++; if (timeout_err !== (k >= 9)) begin bad++; $display("FAIL to_err edge=%0d got=%b exp=%b", k, timeout_err, (k >= 9)); end
      total++; if (busy !== (k <= 9)) begin bad++; $display("FAIL to_busy edge=%0d got=%b exp=%b", k, busy, (k <= 9)); end
      total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL to_done edge=%0d got=%b exp=0", k, xfer_done); end
    end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL to_ready_with_err got=%b exp=1", din_ready); end
    $display("timeout: transfer aborted after 8 wait cycles");
  endtask

  task automatic test_tie();
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", timeout_err); end
    din = 32'h7777_0009;
    for (int k = 1; k <= 10; k++) begin
      din_valid = (k == 1);
      ack_sync  = (k == 9);
      step();
      total++; if (tx_req !== (k <= 8)) begin bad++; $display("FAIL tie_req edge=%0d got=%b exp=%b", k, tx_req, (k <= 8)); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tie_err edge=%0d got=%b exp=0", k, timeout_err); end
      total++; if (xfer_done !== (k == 10)) begin bad++; $display("FAIL tie_done edge=%0d got=%b exp=%b", k, xfer_done, (k == 10)); end
    end
    din = 32'h7777_000A;
    ack_sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      din_valid   = (k == 1);
      timeout_clr = (k == 9);
      step();
      total++; if (timeout_err !== (k >= 9)) begin bad++; $display("FAIL setclr_err edge=%0d got=%b exp=%b", k, timeout_err, (k >= 9)); end
    end
    timeout_clr = 1'b0;
    $display("tie: ack-wins and set-beats-clear cases run");
  endtask

  task automatic test_stale_ack();
    din = 32'hC0DE_0001;
    din_valid = 1'b1;
    ack_sync  = 1'b1;
    #1;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL stale_ready got=%b exp=0", din_ready); end
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stale_busy edge=%0d got=%b exp=0", k, busy); end
      total++; if (tx_data !== 32'h7777_000A) begin bad++; $display("FAIL stale_data edge=%0d got=%h exp=7777000a", k, tx_data); end
    end
    ack_sync = 1'b0;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL stale_ready_after got=%b exp=1", din_ready); end
    step();
    total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL stale_accept_req got=%b exp=1", tx_req); end
    total++; if (tx_data !== 32'hC0DE_0001) begin bad++; $display("FAIL stale_accept_data got=%h exp=c0de0001", tx_data); end
    din_valid = 1'b0; ack_sync = 1'b1;
    step();
    ack_sync = 1'b0;
    step();
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL stale_done got=%b exp=1", xfer_done); end
    $display("stale_ack: accept held off until ack low");
  endtask

  task automatic test_reset_mid();
    din = 32'hBEEF_0002;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b exp=1", tx_req); end
    reset = 1'b1;
    step();
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", tx_req); end
    total++; if (tx_data !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", tx_data); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", xfer_done); end
    reset = 1'b0;
    step();
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL rmid_done_after got=%b exp=0", xfer_done); end
    din = 32'hBEEF_0003;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL rmid_accept_req got=%b exp=1", tx_req); end
    total++; if (tx_data !== 32'hBEEF_0003) begin bad++; $display("FAIL rmid_accept_data got=%h exp=beef0003", tx_data); end
    ack_sync = 1'b1;
    step();
    ack_sync = 1'b0;
    step();
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL rmid_final_done got=%b exp=1", xfer_done); end
    $display("reset_mid: abort and clean restart run");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_tie();
    test_stale_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
